// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared core constants for the common-data-bus arbiter:
//   * default data/control/ROB/requester widths
//   * functional-unit index constants (ALU0, ALU1, branch, load/store)
//   * saturation limit of the conflict counter
//   * ptr_width(): index width for a round-robin pointer over n requesters
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

    localparam int WIDTH_DEF   = 31;  // result/target MSB index
    localparam int CONTROL_DEF = 7;   // MSB of {isControl,pcControl}
    localparam int ROB_DEF     = 2;   // ROB tag MSB index
    localparam int NREQ_DEF    = 4;   // number of requesting units

    typedef enum logic [1:0] {
        UNIT_ALU0   = 2'd0,
        UNIT_ALU1   = 2'd1,
        UNIT_BRANCH = 2'd2,
        UNIT_LSU    = 2'd3
    } unit_e;

    localparam logic [15:0] CONFLICT_MAX = 16'hFFFF;

    // Width of an index over n entries; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
// Bundle between the functional units / reorder buffer and the CDB arbiter.
//   Requester side : req, req_rob, req_result, req_target, req_isControl,
//                    req_pcControl, flush
//   Arbiter side   : grant (combinational), validBroadcast, robEntry, result,
//                    targetAddress, isControl, pcControl (registered CDB drive),
//                    conflict_cnt
// Modports: master = requesters/ROB, slave = arbiter.
// -----------------------------------------------------------------------------
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int CONTROL = CONTROL_DEF,
    parameter int ROB     = ROB_DEF,
    parameter int NREQ    = NREQ_DEF
) ();

    logic [NREQ-1:0]               req;
    logic [NREQ-1:0][ROB:0]        req_rob;
    logic [NREQ-1:0][WIDTH:0]      req_result;
    logic [NREQ-1:0][WIDTH:0]      req_target;
    logic [NREQ-1:0]               req_isControl;
    logic [NREQ-1:0][CONTROL-1:0]  req_pcControl;
    logic                          flush;

    logic [NREQ-1:0]               grant;
    logic                          validBroadcast;
    logic [ROB:0]                  robEntry;
    logic [WIDTH:0]                result;
    logic [WIDTH:0]                targetAddress;
    logic                          isControl;
    logic [CONTROL-1:0]            pcControl;
    logic [15:0]                   conflict_cnt;

    modport master (
        output req, req_rob, req_result, req_target, req_isControl,
               req_pcControl, flush,
        input  grant, validBroadcast, robEntry, result, targetAddress,
               isControl, pcControl, conflict_cnt
    );

    modport slave (
        input  req, req_rob, req_result, req_target, req_isControl,
               req_pcControl, flush,
        output grant, validBroadcast, robEntry, result, targetAddress,
               isControl, pcControl, conflict_cnt
    );

endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin pick: searches req ascending from ptr, wrapping
// NREQ-1 -> 0 (NREQ need not be a power of two).
//   req    : request vector
//   ptr    : search start index (0..NREQ-1)
//   grant  : one-hot winner (all zero when no request)
//   winner : index of the winner
//   valid  : some request was found
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int NREQ = 4,
    parameter int PTRW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PTRW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [PTRW-1:0] winner,
    output logic            valid
);

    always_comb begin
        int unsigned idx;
        grant  = '0;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int unsigned off = 0; off < 32'(NREQ); off++) begin
            // Wrap by subtraction rather than modulo so any NREQ works.
            idx = 32'(ptr) + off;
            if (idx >= 32'(NREQ)) begin
                idx = idx - 32'(NREQ);
            end
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                winner     = PTRW'(idx);
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Round-robin arbiter driving the common data bus from NREQ functional units.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : cdb_arbiter_if.slave
//           - grant        one-hot, combinational acceptance this cycle
//           - CDB fields   registered one cycle after the grant
//           - conflict_cnt saturating count of cycles with >=2 requests
// flush kills the current grant and the next broadcast, leaving ptr as is.
// -----------------------------------------------------------------------------
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int CONTROL = CONTROL_DEF,
    parameter int ROB     = ROB_DEF,
    parameter int NREQ    = NREQ_DEF
) (
    input logic          clk,
    input logic          rst_n,
    cdb_arbiter_if.slave bus
);

    localparam int PTRW = ptr_width(NREQ);

    logic [PTRW-1:0]    ptr_q,      ptr_d;
    logic               valid_q,    valid_d;
    logic [ROB:0]       rob_q,      rob_d;
    logic [WIDTH:0]     result_q,   result_d;
    logic [WIDTH:0]     target_q,   target_d;
    logic               isctl_q,    isctl_d;
    logic [CONTROL-1:0] pcctl_q,    pcctl_d;
    logic [15:0]        conflict_q, conflict_d;

    logic [NREQ-1:0]    pick_grant;
    logic [PTRW-1:0]    win;
    logic               pick_valid;
    logic               grant_valid;
    int unsigned        n_req;

    rr_picker #(
        .NREQ (NREQ),
        .PTRW (PTRW)
    ) u_picker (
        .req    (bus.req),
        .ptr    (ptr_q),
        .grant  (pick_grant),
        .winner (win),
        .valid  (pick_valid)
    );

    // Grant is suppressed during flush and while reset is held.
    assign grant_valid = pick_valid && !bus.flush && rst_n;
    assign bus.grant   = grant_valid ? pick_grant : '0;

    always_comb begin
        n_req = 0;
        for (int unsigned i = 0; i < 32'(NREQ); i++) begin
            n_req = n_req + 32'(bus.req[i]);
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        valid_d    = 1'b0;
        isctl_d    = 1'b0;
        pcctl_d    = '0;
        rob_d      = rob_q;
        result_d   = result_q;
        target_d   = target_q;
        conflict_d = conflict_q;

        if (grant_valid) begin
            valid_d  = 1'b1;
            rob_d    = bus.req_rob[win];
            result_d = bus.req_result[win];
            target_d = bus.req_target[win];
            isctl_d  = bus.req_isControl[win];
            pcctl_d  = bus.req_pcControl[win];
            ptr_d    = (win == PTRW'(NREQ - 1)) ? '0 : win + 1'b1;
        end

        if (!bus.flush && n_req >= 2 && conflict_q != CONFLICT_MAX) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            valid_q    <= 1'b0;
            rob_q      <= '0;
            result_q   <= '0;
            target_q   <= '0;
            isctl_q    <= 1'b0;
            pcctl_q    <= '0;
            conflict_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            valid_q    <= valid_d;
            rob_q      <= rob_d;
            result_q   <= result_d;
            target_q   <= target_d;
            isctl_q    <= isctl_d;
            pcctl_q    <= pcctl_d;
            conflict_q <= conflict_d;
        end
    end

    assign bus.validBroadcast = valid_q;
    assign bus.robEntry       = rob_q;
    assign bus.result         = result_q;
    assign bus.targetAddress  = target_q;
    assign bus.isControl      = isctl_q;
    assign bus.pcControl      = pcctl_q;
    assign bus.conflict_cnt   = conflict_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Self-checking bench for cdb_arbiter: table of {req, flush, expected grant}
// vectors plus hand sequences (reset, full contention, async reset, saturation).
// Expected CDB words are queued when a grant is expected and compared one
// cycle later.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.WIDTH(31), .CONTROL(7), .ROB(2), .NREQ(4)) bus ();

    cdb_arbiter #(.WIDTH(31), .CONTROL(7), .ROB(2), .NREQ(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        valid;
        logic [2:0]  rob;
        logic [31:0] result;
        logic [31:0] target;
        logic        isctl;
        logic [6:0]  pcctl;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        logic       flush;
        logic [3:0] grant;
        string      name;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [15:0] exp_cnt;
    logic [2:0]  last_rob;
    logic [31:0] last_result;
    logic [31:0] last_target;

    logic [2:0]  p_rob [4];
    logic [31:0] p_res [4];
    logic [31:0] p_tgt [4];
    logic        p_ctl [4];
    logic [6:0]  p_pc  [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Compare registered CDB outputs against the oldest queued expectation.
    task automatic check_prev(input string nm);
        exp_t e;
        chk({nm, "/conflict_cnt"}, 32'(bus.conflict_cnt), 32'(exp_cnt));
        chk({nm, "/isctl_gated"}, 32'(bus.isControl & ~bus.validBroadcast), 32'd0);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({nm, "/valid"},  32'(bus.validBroadcast), 32'(e.valid));
            chk({nm, "/rob"},    32'(bus.robEntry),       32'(e.rob));
            chk({nm, "/result"}, bus.result,              e.result);
            chk({nm, "/target"}, bus.targetAddress,       e.target);
            chk({nm, "/isctl"},  32'(bus.isControl),      32'(e.isctl));
            chk({nm, "/pcctl"},  32'(bus.pcControl),      32'(e.pcctl));
        end
    endtask

    task automatic drive_and_check(input logic [3:0] r, input logic f,
                                   input logic [3:0] eg, input string nm);
        exp_t e;
        bus.req   = r;
        bus.flush = f;
        #1;
        chk({nm, "/grant"}, 32'(bus.grant), 32'(eg));
        e.valid  = 1'b0;
        e.isctl  = 1'b0;
        e.pcctl  = '0;
        e.rob    = last_rob;
        e.result = last_result;
        e.target = last_target;
        for (int k = 0; k < 4; k++) begin
            if (eg[k]) begin
                e.valid     = 1'b1;
                e.rob       = p_rob[k];
                e.result    = p_res[k];
                e.target    = p_tgt[k];
                e.isctl     = p_ctl[k];
                e.pcctl     = p_pc[k];
                last_rob    = p_rob[k];
                last_result = p_res[k];
                last_target = p_tgt[k];
            end
        end
        sb.push_back(e);
        if (!f && $countones(r) >= 2 && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic do_cycle(input logic [3:0] r, input logic f,
                            input logic [3:0] eg, input string nm);
        @(negedge clk);
        check_prev(nm);
        drive_and_check(r, f, eg, nm);
    endtask

    // Assert reset asynchronously wherever we are and check immediate clear.
    task automatic reset_assert(input logic [3:0] hold_req, input string nm);
        exp_t z;
        rst_n     = 1'b0;
        bus.req   = hold_req;
        bus.flush = 1'b0;
        #1;
        sb.delete();
        exp_cnt     = '0;
        last_rob    = '0;
        last_result = '0;
        last_target = '0;
        chk({nm, "/grant"},  32'(bus.grant),          32'd0);
        chk({nm, "/valid"},  32'(bus.validBroadcast), 32'd0);
        chk({nm, "/rob"},    32'(bus.robEntry),       32'd0);
        chk({nm, "/result"}, bus.result,              32'd0);
        chk({nm, "/target"}, bus.targetAddress,       32'd0);
        chk({nm, "/isctl"},  32'(bus.isControl),      32'd0);
        chk({nm, "/pcctl"},  32'(bus.pcControl),      32'd0);
        chk({nm, "/cnt"},    32'(bus.conflict_cnt),   32'd0);
        repeat (2) @(negedge clk);
        #1;
        chk({nm, "/grant_held"}, 32'(bus.grant), 32'd0);
        z = '{valid: 1'b0, rob: '0, result: '0, target: '0, isctl: 1'b0, pcctl: '0};
        sb.push_back(z);
    endtask

    task automatic release_reset(input logic [3:0] r, input logic [3:0] eg, input string nm);
        @(negedge clk);
        check_prev(nm);
        rst_n = 1'b1;
        drive_and_check(r, 1'b0, eg, nm);
    endtask

    vec_t       vecs[$];
    logic [3:0] full_exp[7];

    initial begin
        for (int i = 0; i < 4; i++) begin
            p_rob[i] = 3'(i + 1);
            p_res[i] = 32'h1000_0000 + 32'(i);
            p_tgt[i] = 32'hA000_0000 + 32'(i * 16);
            p_ctl[i] = 1'b0;
            p_pc[i]  = 7'(i + 1);
        end
        p_rob[2] = 3'd5;  p_res[2] = 32'hDEADBEEF; p_ctl[2] = 1'b1; p_pc[2] = 7'h55;
        p_rob[3] = 3'd6;  p_ctl[3] = 1'b1;         p_pc[3] = 7'h2A;
        for (int i = 0; i < 4; i++) begin
            bus.req_rob[i]       = p_rob[i];
            bus.req_result[i]    = p_res[i];
            bus.req_target[i]    = p_tgt[i];
            bus.req_isControl[i] = p_ctl[i];
            bus.req_pcControl[i] = p_pc[i];
        end
        bus.req   = '0;
        bus.flush = 1'b0;
        exp_cnt   = '0;
        last_rob = '0; last_result = '0; last_target = '0;

        // pointer walk after the single unit-2 grant leaves ptr = 3
        vecs = '{
            '{4'b0000, 1'b0, 4'b0000, "idle_after_ctl"},
            '{4'b1111, 1'b0, 4'b1000, "ptr3_all"},
            '{4'b0011, 1'b1, 4'b0000, "flush"},
            '{4'b0011, 1'b0, 4'b0001, "post_flush"},
            '{4'b0011, 1'b0, 4'b0010, "pair_b"},
            '{4'b0011, 1'b0, 4'b0001, "pair_wrap"},
            '{4'b1000, 1'b0, 4'b1000, "lone3"},
            '{4'b0110, 1'b0, 4'b0010, "mid_a"},
            '{4'b0110, 1'b0, 4'b0100, "mid_b"},
            '{4'b0110, 1'b0, 4'b0010, "mid_wrap"},
            '{4'b0001, 1'b1, 4'b0000, "flush_single"},
            '{4'b1001, 1'b0, 4'b1000, "ends_a"},
            '{4'b1001, 1'b0, 4'b0001, "ends_b"},
            '{4'b0000, 1'b0, 4'b0000, "idle_end"}
        };

        #2;
        reset_assert(4'b1111, "rst0");
        release_reset(4'b0000, 4'b0000, "rel0");

        do_cycle(4'b0100, 1'b0, 4'b0100, "single");
        foreach (vecs[i]) do_cycle(vecs[i].req, vecs[i].flush, vecs[i].grant, vecs[i].name);
        do_cycle(4'b0000, 1'b0, 4'b0000, "drain0");

        // full contention from reset
        reset_assert(4'b0000, "rst1");
        release_reset(4'b1111, 4'b0001, "full0");
        full_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 7; i++) do_cycle(4'b1111, 1'b0, full_exp[i], "full");
        do_cycle(4'b0000, 1'b0, 4'b0000, "full_idle");
        chk("full_conflict_8", 32'(bus.conflict_cnt), 32'd8);

        // async reset between edges mid-stream, then restart from ptr 0
        do_cycle(4'b1010, 1'b0, 4'b0010, "pre_rst_a");
        do_cycle(4'b1010, 1'b0, 4'b1000, "pre_rst_b");
        @(posedge clk);
        #2;
        chk("pre_rst_valid", 32'(bus.validBroadcast), 32'd1);
        reset_assert(4'b1010, "async_rst");
        release_reset(4'b1010, 4'b0010, "rst_release");
        do_cycle(4'b0000, 1'b0, 4'b0000, "post_rst_a");
        do_cycle(4'b0000, 1'b0, 4'b0000, "post_rst_b");

        // saturation
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            bus.req = 4'b0110;
        end
        @(negedge clk);
        chk("sat", 32'(bus.conflict_cnt), 32'h0000FFFF);
        repeat (3) @(negedge clk);
        chk("sat_hold", 32'(bus.conflict_cnt), 32'h0000FFFF);
        bus.req = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
